// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared processor package for the pipeline hazard controller.
// Holds the register-specifier width and the action/state encoding that is
// reported on the controller's registered state output.
package pipe_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 4;

  // Action selected each cycle; also the value registered on `state`.
  typedef enum logic [2:0] {
    ACT_RUN        = 3'd0,
    ACT_DMEM_WAIT  = 3'd1,
    ACT_REDIRECT   = 3'd2,
    ACT_LOAD_STALL = 3'd3,
    ACT_IMEM_WAIT  = 3'd4
  } action_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: saturating up-counter used for the performance counters.
// Ports:
//   clk    - clock, rising edge
//   clr    - synchronous clear (wins over inc)
//   inc    - increment by one this cycle, holds at all-ones
//   count  - current count
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-order pipeline hazard controller.
// Chooses one action per cycle (data-memory wait, redirect, load-use stall,
// fetch wait, run) and drives PC enable plus IF/ID and ID/EX latch
// stall/flush controls combinationally. Registers the chosen action on
// `state`, keeps stall/flush performance counters and a sticky data-memory
// timeout flag.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   id_valid, id_rs1/2, id_use_*  - ID stage instruction and sources
//   ex_is_load, ex_rd             - EX stage load and destination
//   ex_redirect                   - taken branch/jump resolved in EX
//   imem_ready                    - fetch data valid
//   dmem_req, dmem_ready          - MEM stage access outstanding / completing
//   pc_en                         - PC write enable
//   if_stall, if_flush            - IF/ID latch controls
//   id_stall, id_flush            - ID/EX latch controls
//   state                         - action selected in the previous cycle
//   stall_count, flush_count      - saturating performance counters
//   mem_timeout                   - sticky data-memory timeout error
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = pipe_hazard_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int COUNT_WIDTH    = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_use_rs1,
  input  logic                      id_use_rs2,
  input  logic                      ex_is_load,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_redirect,
  input  logic                      imem_ready,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_en,
  output logic                      if_stall,
  output logic                      if_flush,
  output logic                      id_stall,
  output logic                      id_flush,
  output logic [2:0]                state,
  output logic [COUNT_WIDTH-1:0]    stall_count,
  output logic [COUNT_WIDTH-1:0]    flush_count,
  output logic                      mem_timeout
);

  logic    hazard;
  action_e act;
  action_e state_q;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;

  // Register x0 is hardwired to zero, so a load targeting it never blocks.
  assign hazard = id_valid && ex_is_load && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                   (id_use_rs2 && (id_rs2 == ex_rd)));

  // Data-memory wait has top priority: EX is frozen, so a redirect seen
  // there is replayed once the wait ends.
  always_comb begin
    if (dmem_req && !dmem_ready) act = ACT_DMEM_WAIT;
    else if (ex_redirect)        act = ACT_REDIRECT;
    else if (hazard)             act = ACT_LOAD_STALL;
    else if (!imem_ready)        act = ACT_IMEM_WAIT;
    else                         act = ACT_RUN;
  end

  always_comb begin
    pc_en    = 1'b1;
    if_stall = 1'b0;
    if_flush = 1'b0;
    id_stall = 1'b0;
    id_flush = 1'b0;
    if (reset) begin
      // Hold the front end empty while in reset.
      pc_en    = 1'b0;
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else begin
      unique case (act)
        ACT_DMEM_WAIT: begin
          pc_en    = 1'b0;
          if_stall = 1'b1;
          id_stall = 1'b1;
        end
        ACT_REDIRECT: begin
          if_flush = 1'b1;
          id_flush = 1'b1;
        end
        ACT_LOAD_STALL: begin
          pc_en    = 1'b0;
          if_stall = 1'b1;
          id_flush = 1'b1;
        end
        ACT_IMEM_WAIT: begin
          pc_en    = 1'b0;
          if_flush = 1'b1;
        end
        default: begin
          pc_en = 1'b1;
        end
      endcase
    end
  end

  assign wait_nxt = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACT_RUN;
      wait_cnt    <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= act;
      if (act == ACT_DMEM_WAIT) begin
        wait_cnt <= wait_nxt;
        // Flag on the same edge the count reaches the limit.
        if (int'(wait_nxt) >= TIMEOUT) mem_timeout <= 1'b1;
      end else begin
        wait_cnt <= 8'd0;
      end
    end
  end

  assign state = state_q;

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (!pc_en),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(COUNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .clr   (reset),
    .inc   (act == ACT_REDIRECT),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT=4) plus a
// narrow sat_counter instance to reach saturation quickly.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [3:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        ex_is_load;
  logic [3:0]  ex_rd;
  logic        ex_redirect;
  logic        imem_ready;
  logic        dmem_req, dmem_ready;
  logic        pc_en, if_stall, if_flush, id_stall, id_flush;
  logic [2:0]  state;
  logic [31:0] stall_count, flush_count;
  logic        mem_timeout;

  logic        sc_clr, sc_inc;
  logic [1:0]  sc_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_WIDTH(4), .COUNT_WIDTH(32), .TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_is_load  (ex_is_load),
    .ex_rd       (ex_rd),
    .ex_redirect (ex_redirect),
    .imem_ready  (imem_ready),
    .dmem_req    (dmem_req),
    .dmem_ready  (dmem_ready),
    .pc_en       (pc_en),
    .if_stall    (if_stall),
    .if_flush    (if_flush),
    .id_stall    (id_stall),
    .id_flush    (id_flush),
    .state       (state),
    .stall_count (stall_count),
    .flush_count (flush_count),
    .mem_timeout (mem_timeout)
  );

  sat_counter #(.WIDTH(2)) u_sc (
    .clk   (clk),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .count (sc_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs packed as {pc_en, if_stall, if_flush, id_stall, id_flush}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {59'd0, pc_en, if_stall, if_flush, id_stall, id_flush}, {59'd0, exp});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid    = 1'b0;
    id_rs1      = 4'd0;
    id_rs2      = 4'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_is_load  = 1'b0;
    ex_rd       = 4'd0;
    ex_redirect = 1'b0;
    imem_ready  = 1'b1;
    dmem_req    = 1'b0;
    dmem_ready  = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_load_use();
    id_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 4'd3;
    id_rs1     = 4'd5;
    id_use_rs1 = 1'b1;
    id_rs2     = 4'd3;
    id_use_rs2 = 1'b1;
  endtask

  initial begin
    sc_clr = 1'b1;
    sc_inc = 1'b0;
    idle();
    reset = 1'b1;
    #1;
    step();
    // Reset overrides everything on the combinational outputs.
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; set_load_use();
    #1;
    check_ctl("reset_ctl", 5'b00101);
    step();
    idle();
    reset = 1'b0;
    #1;
    check("reset_state", state, 3'd0);
    check("reset_stall_cnt", stall_count, 0);
    check("reset_flush_cnt", flush_count, 0);
    check("reset_timeout", mem_timeout, 0);
    check_ctl("run_ctl", 5'b10000);

    // Load-use on rs2.
    set_load_use();
    id_use_rs1 = 1'b0;
    #1;
    check_ctl("load_use_ctl", 5'b01001);
    step();
    idle();
    #1;
    check("load_use_state", state, 3'd3);
    check("load_use_stall_cnt", stall_count, 1);
    check_ctl("after_load_use_ctl", 5'b10000);
    step();
    check("run_state", state, 3'd0);

    // Redirect wins over a simultaneous hazard.
    set_load_use();
    ex_redirect = 1'b1;
    #1;
    check_ctl("redirect_ctl", 5'b10101);
    step();
    idle();
    #1;
    check("redirect_state", state, 3'd2);
    check("redirect_flush_cnt", flush_count, 1);
    check("redirect_stall_cnt", stall_count, 1);

    // Five-cycle data-memory wait with redirect held, then the redirect.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_ctl($sformatf("dwait_ctl_%0d", i), 5'b01010);
      step();
      check($sformatf("dwait_state_%0d", i), state, 3'd1);
      if (i == 2) check("dwait_no_timeout_3", mem_timeout, 0);
    end
    dmem_ready = 1'b1;
    #1;
    check_ctl("dwait_redirect_ctl", 5'b10101);
    step();
    idle();
    #1;
    check("dwait_redirect_state", state, 3'd2);
    check("dwait_stall_cnt", stall_count, 5);
    check("dwait_flush_cnt", flush_count, 1);
    check("dwait_timeout_set", mem_timeout, 1);

    // Timeout boundary: set after exactly 4 waits, sticky afterwards.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(); step(); step();
    check("to_after3", mem_timeout, 0);
    step();
    check("to_after4", mem_timeout, 1);
    dmem_ready = 1'b1;
    step();
    idle();
    step(); step();
    check("to_sticky", mem_timeout, 1);
    check("to_state_run", state, 3'd0);

    // Reset in the 3rd cycle of a wait.
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    check_ctl("mid_reset_ctl", 5'b00101);
    step();
    reset = 1'b0;
    idle();
    #1;
    check("mid_reset_state", state, 3'd0);
    check("mid_reset_stall_cnt", stall_count, 0);
    check("mid_reset_flush_cnt", flush_count, 0);
    check_ctl("mid_reset_run_ctl", 5'b10000);
    // Wait counter must have restarted from zero.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    step(); step(); step();
    check("mid_reset_wait_cleared", mem_timeout, 0);
    idle();
    step();

    // Load to x0 never stalls; other non-hazard cases.
    do_reset();
    id_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd0;
    id_rs1 = 4'd0; id_rs2 = 4'd0; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    #1;
    check_ctl("x0_ctl", 5'b10000);
    step();
    check("x0_state", state, 3'd0);
    check("x0_stall_cnt", stall_count, 0);
    idle();
    id_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd7; id_rs1 = 4'd7; id_use_rs1 = 1'b0;
    #1;
    check_ctl("unused_src_ctl", 5'b10000);
    id_use_rs1 = 1'b1; id_valid = 1'b0;
    #1;
    check_ctl("invalid_id_ctl", 5'b10000);
    id_valid = 1'b1; ex_is_load = 1'b0;
    #1;
    check_ctl("not_load_ctl", 5'b10000);
    ex_is_load = 1'b1;
    #1;
    check_ctl("rs1_hazard_ctl", 5'b01001);
    idle();

    // Fetch wait, and hazard has priority over it.
    imem_ready = 1'b0;
    #1;
    check_ctl("imem_ctl", 5'b00100);
    step();
    check("imem_state", state, 3'd4);
    check("imem_stall_cnt", stall_count, 1);
    set_load_use();
    #1;
    check_ctl("hazard_over_imem_ctl", 5'b01001);
    idle();
    step();

    // Saturating counter at width 2.
    sc_clr = 1'b1;
    step();
    sc_clr = 1'b0; sc_inc = 1'b1;
    step(); step(); step();
    check("sat_reach_max", sc_count, 3);
    step(); step();
    check("sat_hold_max", sc_count, 3);
    sc_inc = 1'b0; sc_clr = 1'b1;
    step();
    check("sat_clear", sc_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- REG_ADDR_WIDTH, 4, register-specifier width.
- COUNT_WIDTH, 32, performance-counter width.
- TIMEOUT, 255, maximum consecutive data-memory wait cycles before an error is flagged.

REQ-002 Ports (name direction width meaning) SHALL be:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_ADDR_WIDTH  ID source registers.
- id_use_rs1, id_use_rs2  in  1  source actually read.
- ex_is_load  in  1  EX stage holds a load.
- ex_rd  in  REG_ADDR_WIDTH  EX destination register.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage access outstanding.
- dmem_ready  in  1  data memory completes this cycle.
- pc_en  out  1  PC register write enable.
- if_stall, if_flush  out  1  IF/ID latch controls.
- id_stall, id_flush  out  1  ID/EX latch controls.
- state  out  3  registered action of the previous cycle.
- stall_count, flush_count  out  COUNT_WIDTH  performance counters.
- mem_timeout  out  1  sticky timeout error.

Function
REQ-003 A load-use hazard SHALL be computed combinationally when all of the following hold:
- id_valid=1, ex_is_load=1 and ex_rd!=0;
- (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd).

REQ-004 Each cycle exactly one action SHALL be selected, in the priority order of REQ-005 to REQ-009.

REQ-005 DMEM_WAIT (dmem_req=1 and dmem_ready=0): pc_en=0, if_stall=1, id_stall=1, both flushes 0.

REQ-006 REDIRECT (ex_redirect=1): pc_en=1, if_flush=1, id_flush=1, both stalls 0.

REQ-007 LOAD_STALL (hazard): pc_en=0, if_stall=1, id_flush=1 (bubble into EX), id_stall=0.

REQ-008 IMEM_WAIT (imem_ready=0): pc_en=0, if_flush=1 (bubble into ID), id_stall=0, id_flush=0.

REQ-009 RUN (otherwise): pc_en=1, all stalls and flushes 0.

REQ-010 The stall and flush outputs SHALL be combinational, with zero-cycle latency from the inputs.

REQ-011 state SHALL register the selected action with encoding RUN=0, DMEM_WAIT=1, REDIRECT=2, LOAD_STALL=3, IMEM_WAIT=4; values 5 to 7 are never produced.

REQ-012 stall_count SHALL increment on every cycle with pc_en=0, and saturate at all-ones.

REQ-013 flush_count SHALL increment on every REDIRECT cycle, and saturate at all-ones.

REQ-014 An 8-bit wait counter SHALL:
- increment on each consecutive DMEM_WAIT cycle;
- clear on any other action;
- set mem_timeout when it reaches TIMEOUT; mem_timeout then stays 1 until reset.

REQ-015 ex_redirect asserted during DMEM_WAIT SHALL be ignored for that cycle; upstream keeps it asserted because the EX latch is stalled.

REQ-016 A hazard with ex_rd==0 SHALL never stall.

REQ-017 if_stall and if_flush SHALL never both be 1 in the same cycle; the same SHALL hold for id_stall and id_flush.

Reset
REQ-018 On a reset cycle the following SHALL be cleared at the next edge:
- state=RUN;
- stall_count=0, flush_count=0;
- wait counter=0;
- mem_timeout=0.

REQ-019 While reset=1, the combinational outputs SHALL be pc_en=0, if_flush=1, id_flush=1, both stalls 0, regardless of the other inputs.

REQ-020 Reset asserted mid-DMEM_WAIT SHALL abandon the wait with no residual stall on the first cycle after reset.

Structure
REQ-021 The state encoding constants and REG_ADDR_WIDTH SHALL live in the shared processor package; COUNT_WIDTH and TIMEOUT stay module parameters.

REQ-022 One sub-module, sat_counter (parameterised width, inc, clr), SHALL implement both performance counters.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Load-use: ex_is_load=1, ex_rd=3, id_rs2=3, id_use_rs2=1 -> one cycle pc_en=0, if_stall=1, id_flush=1, state=3 next cycle, stall_count=1.
- Redirect with simultaneous hazard: ex_redirect=1 -> if_flush=id_flush=1, pc_en=1, flush_count increments, stall_count unchanged.
- Data-memory wait of 5 cycles with ex_redirect=1 throughout -> 5 cycles of full stall, then a REDIRECT cycle; stall_count=5, flush_count=1.
- Timeout with TIMEOUT=4: hold dmem_ready=0 for 4 cycles -> mem_timeout=1, still 1 after dmem_ready=1.
- Reset on the 3rd cycle of a data-memory wait -> next cycle state=0, counters 0, pc_en=1 with imem_ready=1.
- ex_rd=0 load with matching sources -> RUN, no stall.
